cart_rom_engine: RTL and testbench
==================================

CART_ROM_ENGINE -- requirements
Module: cart_rom_engine

Interface
REQ-001 Parameter BANK_BITS, default 3; bank-register width; banks = 2^BANK_BITS, each bank 16 KiB (8 KiB ROML + 8 KiB ROMH).
REQ-002 Parameter AW = 14+BANK_BITS, derived; ROM storage address width; depth 2^AW bytes.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mode  in  2  cart mode: 00 off, 01 8K, 10 16K, 11 ultimax; sampled every cycle.
REQ-006 load_start  in  1  one-cycle pulse; begins image load.
REQ-007 load_end  in  1  one-cycle pulse; ends image load.
REQ-008 ld_req  in  1  toggle-type write request from flash loader.
REQ-009 ld_ack  out  1  toggle acknowledge; equals ld_req one cycle after acceptance.
REQ-010 ld_addr  in  AW  byte address of loader write.
REQ-011 ld_data  in  8  loader write data.
REQ-012 bus_a  in  16  C64 address bus, async.
REQ-013 bus_d  in  8  C64 data bus input, async.
REQ-014 rw  in  1  C64 R/W, async, 1 = read.
REQ-015 roml_n, romh_n, io1_n  in  1 each  C64 strobes, async, active low.
REQ-016 rd_data  out  8  data to drive onto C64 bus.
REQ-017 data_oe  out  1  drive enable for rd_data.
REQ-018 exrom_n, game_n  out  1 each  cartridge config lines, active low.
REQ-019 busy  out  1  high while in LOAD.

Function
REQ-020 Strobes rw, roml_n, romh_n, io1_n pass through a 2-flop synchroniser; edges detected on synchronised copies; bus_a, bus_d sampled on the same cycle as the detected edge.
REQ-021 FSM states IDLE, LOAD, RUN; IDLE->LOAD and RUN->LOAD on load_start; LOAD->RUN on load_end; load_end outside LOAD ignored; load_start and load_end in the same cycle: load_start wins.
REQ-022 Entering LOAD clears the bank register to 0.
REQ-023 Loader: new request when ld_req != ld_ack; in LOAD, write ld_data at ld_addr and set ld_ack <= ld_req in that same cycle; outside LOAD, acknowledge without writing.
REQ-024 Strobe reads are served only in RUN with mode != 00; in IDLE/LOAD, data_oe = 0 and no read occurs.
REQ-025 Read address = {bank, romh_sel, bus_a[12:0]}; romh_sel = 1 for ROMH, 0 for ROML; in mode 01, ROMH strobes are ignored.
REQ-026 Read latency: rd_data valid and data_oe = 1 exactly 2 cycles after the synchronised falling strobe edge; held until the synchronised strobe rises, then data_oe = 0 the next cycle.
REQ-027 Bank write: on synchronised rising edge of io1_n with rw = 0 in RUN, bank <= bus_d[BANK_BITS-1:0]; upper bits ignored, so values wrap modulo 2^BANK_BITS.
REQ-028 bus_d bit 7 = 1 on a bank write sets the kill flag; while kill is set, exrom_n = game_n = 1 and no reads are served; kill is cleared by reset or load_start.
REQ-029 Config lines in RUN (not killed): mode 00 -> 1/1; 01 -> 0/1; 10 -> 0/0; 11 -> 1/0 (exrom_n/game_n); in IDLE/LOAD -> 1/1.
REQ-030 ld_addr wraps at 2^AW; no range checking is performed.

Reset
REQ-031 On reset: state = IDLE; bank = 0; kill = 0; ld_ack = ld_req; data_oe = 0; rd_data = 0; exrom_n = game_n = 1; busy = 0; synchroniser flops = 1 for active-low strobes and for rw.
REQ-032 Reset during LOAD aborts the load; ROM contents are retained; no write occurs in the reset cycle.

Configuration
REQ-033 Macro CART_BANK_READBACK_EN defined: an io1_n read (rw = 1) in RUN drives {kill, 0 padding, bank} with the same timing as REQ-026.
REQ-034 Macro CART_BANK_READBACK_EN not defined: io1_n reads are ignored and data_oe stays 0.

Verification
REQ-035 load_start; 4 toggle writes 0x11..0x14 at addresses 0x0000..0x0003; load_end; ROML read at $8002 -> rd_data = 0x13, data_oe rises 2 cycles after the synchronised edge.
REQ-036 BANK_BITS=3, mode=10: write 0x0A at io1 (bank = 2); ROMH read at $A005 -> returns byte loaded at address 0x0A005.
REQ-037 Bank write 0x85 -> kill set; exrom_n = game_n = 1; subsequent ROML read -> data_oe stays 0; load_start clears kill.
REQ-038 Toggle request while in IDLE -> ld_ack follows 1 cycle later; ROM byte unchanged on readback after load.
REQ-039 Reset asserted mid-LOAD after 2 of 4 writes -> state IDLE, busy = 0, exrom_n = game_n = 1; previously written bytes are retained.
REQ-040 With CART_BANK_READBACK_EN defined, bank = 5, io1 read -> rd_data = 0x05; without the macro -> data_oe = 0.

Source files
------------

// File: rtl/cart_rom_engine.sv
// cart_rom_engine: C64 cartridge ROM emulation with banked ROML/ROMH, toggle-handshake image loader and kill switch.
// Optional macro CART_BANK_READBACK_EN: io1 reads return {kill, 0 padding, bank}.
module cart_rom_engine #(
  parameter int BANK_BITS = 3,
  parameter int AW        = 14 + BANK_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic          load_start,
  input  logic          load_end,
  input  logic          ld_req,
  output logic          ld_ack,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic [15:0]   bus_a,
  input  logic [7:0]    bus_d,
  input  logic          rw,
  input  logic          roml_n,
  input  logic          romh_n,
  input  logic          io1_n,
  output logic [7:0]    rd_data,
  output logic          data_oe,
  output logic          exrom_n,
  output logic          game_n,
  output logic          busy
);
  // state | meaning
  // IDLE  | out of reset, no image yet; bus never served
  // LOAD  | loader writes land in ROM storage; busy high
  // RUN   | image live; strobes served according to mode
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  localparam int B_ROML = 0;
  localparam int B_ROMH = 1;
  localparam int B_IO1  = 2;
  localparam int B_RW   = 3;

  state_t               state_q, state_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 kill_q, kill_d;
  logic                 ld_ack_q, ld_ack_d;
  logic [3:0]           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic                 pend_q, pend_d;
  logic                 oe_q, oe_d;
  logic                 reg_rd_q, reg_rd_d;
  logic [1:0]           strb_q, strb_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic [3:0]           fall, rise;
  logic                 rom_ok, ld_new;
  logic [7:0]           readback;
  logic                 unused_bits;
  logic [7:0]           rom_mem [0:(1<<AW)-1];

  always_comb begin
    sync1_d  = {rw, io1_n, romh_n, roml_n};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    fall     = prev_q & ~sync2_q;
    rise     = ~prev_q & sync2_q;
    ld_new   = (ld_req != ld_ack_q);
    rom_ok   = (state_q == RUN) && (mode != 2'b00) && !kill_q;
    readback = '0;
    readback[BANK_BITS-1:0] = bank_q;
    readback[7] = kill_q;

    // Every request is accepted on sight, so the acknowledge simply tracks the request.
    ld_ack_d = ld_req;

    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (!load_start && load_end) state_d = RUN;
      RUN:     if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase

    bank_d = bank_q;
    kill_d = kill_q;
    if (load_start) begin
      bank_d = '0;
      kill_d = 1'b0;
    end else if (state_q == RUN && rise[B_IO1] && !sync2_q[B_RW]) begin
      bank_d = bus_d[BANK_BITS-1:0];
      if (bus_d[7]) kill_d = 1'b1;
    end

    pend_d    = 1'b0;
    addr_d    = addr_q;
    reg_rd_d  = reg_rd_q;
    strb_d    = strb_q;
    oe_d      = oe_q;
    rd_data_d = rd_data_q;
    if (rom_ok && fall[B_ROML]) begin
      pend_d   = 1'b1;
      addr_d   = {bank_q, 1'b0, bus_a[12:0]};
      reg_rd_d = 1'b0;
      strb_d   = 2'd0;
    end else if (rom_ok && fall[B_ROMH] && mode != 2'b01) begin
      pend_d   = 1'b1;
      addr_d   = {bank_q, 1'b1, bus_a[12:0]};
      reg_rd_d = 1'b0;
      strb_d   = 2'd1;
    end
`ifdef CART_BANK_READBACK_EN
    // Readback ignores mode and kill so software can still see the kill bit.
    else if (state_q == RUN && fall[B_IO1] && sync2_q[B_RW]) begin
      pend_d   = 1'b1;
      reg_rd_d = 1'b1;
      strb_d   = 2'd2;
    end
`endif

    if (pend_q) begin
      oe_d      = 1'b1;
      rd_data_d = reg_rd_q ? readback : rom_mem[addr_q];
    end else if (oe_q && sync2_q[strb_q]) begin
      oe_d = 1'b0;
    end
    if (state_q != RUN || (kill_q && !reg_rd_q)) begin
      pend_d = 1'b0;
      oe_d   = 1'b0;
    end
  end

  assign unused_bits = ^{bus_a, bus_d, fall, rise};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      kill_q    <= 1'b0;
      ld_ack_q  <= ld_req;
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      prev_q    <= 4'hF;
      pend_q    <= 1'b0;
      oe_q      <= 1'b0;
      reg_rd_q  <= 1'b0;
      strb_q    <= 2'd0;
      addr_q    <= '0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      kill_q    <= kill_d;
      ld_ack_q  <= ld_ack_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      oe_q      <= oe_d;
      reg_rd_q  <= reg_rd_d;
      strb_q    <= strb_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage has no reset so an aborted load keeps everything already written.
  always_ff @(posedge clk) begin
    if (!reset && state_q == LOAD && ld_new) rom_mem[ld_addr] <= ld_data;
  end

  always_comb begin
    exrom_n = 1'b1;
    game_n  = 1'b1;
    if (state_q == RUN && !kill_q) begin
      case (mode)
        2'b01:   exrom_n = 1'b0;
        2'b10:   begin exrom_n = 1'b0; game_n = 1'b0; end
        2'b11:   game_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign ld_ack  = ld_ack_q;
  assign rd_data = rd_data_q;
  assign data_oe = oe_q;
  assign busy    = (state_q == LOAD);
endmodule

// File: tb/tb_cart_rom_engine.sv
// tb_cart_rom_engine: vector table, directed corner sequences and randomized reads
// checked against a byte-level cartridge model kept in the bench.
`timescale 1ns/1ps
module tb_cart_rom_engine;
  localparam int BB = 3;
  localparam int AW = 14 + BB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          load_start = 1'b0;
  logic          load_end = 1'b0;
  logic          ld_req = 1'b1;
  logic          ld_ack;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = 8'h00;
  logic [15:0]   bus_a = 16'h0000;
  logic [7:0]    bus_d = 8'h00;
  logic          rw = 1'b1;
  logic          roml_n = 1'b1;
  logic          romh_n = 1'b1;
  logic          io1_n = 1'b1;
  logic [7:0]    rd_data;
  logic          data_oe;
  logic          exrom_n;
  logic          game_n;
  logic          busy;

  always #5 clk = ~clk;

  cart_rom_engine #(.BANK_BITS(BB)) dut (
    .clk(clk), .reset(reset), .mode(mode), .load_start(load_start), .load_end(load_end),
    .ld_req(ld_req), .ld_ack(ld_ack), .ld_addr(ld_addr), .ld_data(ld_data),
    .bus_a(bus_a), .bus_d(bus_d), .rw(rw), .roml_n(roml_n), .romh_n(romh_n), .io1_n(io1_n),
    .rd_data(rd_data), .data_oe(data_oe), .exrom_n(exrom_n), .game_n(game_n), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  // cartridge model: 0 idle, 1 loading, 2 running
  int         m_state = 0;
  int         m_bank = 0;
  int         m_kill = 0;
  logic [7:0] m_mem [int];
  int         wr_q [$];
  logic [1:0] cfg_tab [4];

  typedef struct {
    logic [1:0]  mode;
    int          which;
    logic [15:0] a;
    logic        srv;
    logic [7:0]  d;
    logic        ex;
    logic        gm;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_cfg(input string nm);
    logic [1:0] e;
    e = 2'b11;
    if (m_state == 2 && m_kill == 0) e = cfg_tab[mode];
    chk({nm, "_exrom"}, 32'(exrom_n), 32'(e[1]));
    chk({nm, "_game"}, 32'(game_n), 32'(e[0]));
  endtask

  task automatic model_read(input int which, input logic [15:0] a, output logic srv, output logic [7:0] d);
    int ad;
    srv = 1'b0;
    d = 8'h00;
    if (which == 2) begin
`ifdef CART_BANK_READBACK_EN
      srv = (m_state == 2);
      d = 8'((m_kill << 7) | m_bank);
`endif
    end else begin
      srv = (m_state == 2) && (m_kill == 0) && (mode != 2'b00) && !(which == 1 && mode == 2'b01);
      ad = m_bank * 16384 + which * 8192 + int'(a % 16'h2000);
      if (m_mem.exists(ad)) d = m_mem[ad];
    end
  endtask

  task automatic set_strobe(input int which, input logic v);
    case (which)
      0: roml_n = v;
      1: romh_n = v;
      default: io1_n = v;
    endcase
  endtask

  task automatic do_read(input int which, input logic [15:0] a, input logic srv, input logic [7:0] d, input string nm);
    bus_a = a;
    rw = 1'b1;
    set_strobe(which, 1'b0);
    tick(3);
    chk({nm, "_oe_early"}, 32'(data_oe), 32'd0);
    tick(1);
    chk({nm, "_oe"}, 32'(data_oe), 32'(srv));
    if (srv) chk({nm, "_data"}, 32'(rd_data), 32'(d));
    tick(1);
    chk({nm, "_oe_hold"}, 32'(data_oe), 32'(srv));
    set_strobe(which, 1'b1);
    tick(2);
    chk({nm, "_oe_prerelease"}, 32'(data_oe), 32'(srv));
    tick(1);
    chk({nm, "_oe_drop"}, 32'(data_oe), 32'd0);
    tick(1);
  endtask

  task automatic io1_write(input logic [7:0] v);
    bus_d = v;
    rw = 1'b0;
    io1_n = 1'b0;
    tick(3);
    io1_n = 1'b1;
    tick(4);
    rw = 1'b1;
    tick(3);
    if (m_state == 2) begin
      m_bank = int'(v) % (1 << BB);
      if (v >= 8'h80) m_kill = 1;
    end
  endtask

  task automatic ld_write(input int addr, input logic [7:0] d);
    ld_addr = AW'(addr);
    ld_data = d;
    ld_req = ~ld_req;
    tick(1);
    chk("ld_ack_follow", 32'(ld_ack), 32'(ld_req));
    if (m_state == 1) begin
      if (!m_mem.exists(addr)) wr_q.push_back(addr);
      m_mem[addr] = d;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    m_state = 1;
    m_bank = 0;
    m_kill = 0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    tick(1);
    load_end = 1'b0;
    if (m_state == 1) m_state = 2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       srv;
    logic [7:0] d;
    cfg_tab = '{2'b11, 2'b01, 2'b00, 2'b10};
    vt[0] = '{2'b01, 0, 16'h8000, 1'b1, 8'h11, 1'b0, 1'b1};
    vt[1] = '{2'b01, 1, 16'hA003, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[2] = '{2'b10, 1, 16'hA001, 1'b1, 8'h77, 1'b0, 1'b0};
    vt[3] = '{2'b11, 0, 16'h8003, 1'b1, 8'h14, 1'b1, 1'b0};
    vt[4] = '{2'b00, 0, 16'h8000, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{2'b11, 1, 16'hA001, 1'b1, 8'h77, 1'b1, 1'b0};
    vt[6] = '{2'b10, 0, 16'h8012, 1'b1, 8'h33, 1'b0, 1'b0};

    // reset state
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_exrom", 32'(exrom_n), 32'd1);
    chk("rst_game", 32'(game_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld_ack", 32'(ld_ack), 32'd1);

    // load_end outside LOAD is ignored; loader acks without writing in IDLE
    mode = 2'b01;
    pulse_end();
    chk("idle_end_busy", 32'(busy), 32'd0);
    chk_cfg("idle_end_cfg");
    ld_write(3, 8'hEE);

    // first image
    pulse_start();
    chk("load_busy", 32'(busy), 32'd1);
    chk_cfg("load_cfg");
    for (int i = 0; i < 4; i++) ld_write(i, 8'(8'h11 + i));
    ld_write(32'h00012, 8'h33);
    ld_write(32'h02001, 8'h77);
    ld_write(32'h0A005, 8'h5A);
    for (int i = 0; i < 16; i++) begin
      int ad;
      ad = int'($urandom_range(32'h4000, 32'h1FFFF));
      if (ad == 32'h0A005) ad = 32'h04000;
      ld_write(ad, 8'($urandom_range(0, 255)));
    end
    pulse_end();
    chk("run_busy", 32'(busy), 32'd0);
    chk_cfg("run_cfg");

    do_read(0, 16'h8002, 1'b1, 8'h13, "first_roml");

    for (int i = 0; i < 7; i++) begin
      mode = vt[i].mode;
      tick(1);
      chk($sformatf("vec%0d_exrom", i), 32'(exrom_n), 32'(vt[i].ex));
      chk($sformatf("vec%0d_game", i), 32'(game_n), 32'(vt[i].gm));
      do_read(vt[i].which, vt[i].a, vt[i].srv, vt[i].d, $sformatf("vec%0d", i));
    end

    // bank select and wrap of upper bank-value bits
    mode = 2'b10;
    io1_write(8'h0A);
    do_read(1, 16'hA005, 1'b1, 8'h5A, "bank2_romh");
    io1_write(8'h7A);
    do_read(1, 16'hA005, 1'b1, 8'h5A, "bank_wrap_romh");

    for (int it = 0; it < 24; it++) begin
      int          ad;
      int          which;
      logic [15:0] a;
      ad = wr_q[$urandom_range(0, wr_q.size() - 1)];
      io1_write(8'(((ad >> 14) % 8) + 8 * int'($urandom_range(0, 15))));
      mode = 2'($urandom_range(0, 3));
      tick(1);
      chk_cfg($sformatf("rnd%0d", it));
      which = (ad >> 13) % 2;
      a = 16'(32'h8000 + which * 8192 + ad % 8192);
      model_read(which, a, srv, d);
      do_read(which, a, srv, d, $sformatf("rnd%0d", it));
    end

    // kill switch, cleared by a new load which also zeroes the bank
    mode = 2'b01;
    io1_write(8'h85);
    chk("kill_exrom", 32'(exrom_n), 32'd1);
    chk("kill_game", 32'(game_n), 32'd1);
    do_read(0, 16'h8000, 1'b0, 8'h00, "kill_roml");
    pulse_start();
    chk("kill_reload_busy", 32'(busy), 32'd1);
    pulse_end();
    chk("unkill_exrom", 32'(exrom_n), 32'd0);
    chk("unkill_game", 32'(game_n), 32'd1);
    do_read(0, 16'h8000, 1'b1, 8'h11, "unkill_roml");

    io1_write(8'h05);
`ifdef CART_BANK_READBACK_EN
    do_read(2, 16'hDE00, 1'b1, 8'h05, "io1_readback");
`else
    do_read(2, 16'hDE00, 1'b0, 8'h00, "io1_no_readback");
`endif

    // load_start and load_end together: start wins
    load_start = 1'b1;
    load_end = 1'b1;
    tick(1);
    load_start = 1'b0;
    load_end = 1'b0;
    m_state = 1;
    m_bank = 0;
    m_kill = 0;
    chk("start_wins_busy", 32'(busy), 32'd1);
    pulse_end();
    chk("start_wins_end_busy", 32'(busy), 32'd0);

    // reset mid-load: abort, keep contents, no write in the reset cycle
    mode = 2'b10;
    pulse_start();
    ld_write(32'h10, 8'h21);
    ld_write(32'h11, 8'h22);
    reset = 1'b1;
    ld_addr = AW'(32'h12);
    ld_data = 8'h99;
    ld_req = ~ld_req;
    tick(1);
    reset = 1'b0;
    m_state = 0;
    m_bank = 0;
    m_kill = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_exrom", 32'(exrom_n), 32'd1);
    chk("abort_game", 32'(game_n), 32'd1);
    chk("abort_oe", 32'(data_oe), 32'd0);
    chk("abort_ld_ack", 32'(ld_ack), 32'(ld_req));
    tick(1);
    chk("abort_busy_later", 32'(busy), 32'd0);
    ld_write(0, 8'hEE);
    pulse_start();
    pulse_end();
    mode = 2'b01;
    tick(1);
    do_read(0, 16'h8010, 1'b1, 8'h21, "abort_keep0");
    do_read(0, 16'h8011, 1'b1, 8'h22, "abort_keep1");
    do_read(0, 16'h8012, 1'b1, 8'h33, "abort_nowrite");
    do_read(0, 16'h8000, 1'b1, 8'h11, "idle_nowrite");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
